// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard/forwarding controller.
// Forward-select encodings here must match the execute-stage operand muxes.
package ex_ctrl_pkg;

    localparam int REG_AW = 3;

    localparam logic [1:0] FWD_MEM  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_REG  = 2'b10;
    localparam logic       FWD3_WB  = 1'b0;
    localparam logic       FWD3_REG = 1'b1;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // Metadata of the instruction currently in EX; enough to drive forwarding and load-use checks
    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     use_rs1;
        logic     use_rs2;
        logic     use_rd;
        logic     reg_write;
        logic     mem_read;
    } ex_stage_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     reg_write;
        logic     mem_read;
    } wr_stage_t;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Decode-side bundle between the decode stage and the hazard controller.
// The master is whoever drives decode metadata, flush and hold.
interface ex_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import ex_ctrl_pkg::*;

    reg_idx_t         id_rs1;
    reg_idx_t         id_rs2;
    reg_idx_t         id_rd;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_use_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             hold;
    logic [1:0]       muxFwd1select;
    logic [1:0]       muxFwd2select;
    logic             muxFwd3select;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_use_rd,
               id_reg_write, id_mem_read, flush, hold,
        input  muxFwd1select, muxFwd2select, muxFwd3select, stall, bubble, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_use_rd,
               id_reg_write, id_mem_read, flush, hold,
        output muxFwd1select, muxFwd2select, muxFwd3select, stall, bubble, stall_count
    );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_match.sv
// Single-operand forward source selection: the younger writer in MEM beats the older one in WB.
module fwd_match
    import ex_ctrl_pkg::*;
(
    input  logic       use_i,
    input  reg_idx_t   src_i,
    input  reg_idx_t   mem_rd_i,
    input  logic       mem_we_i,
    input  reg_idx_t   wb_rd_i,
    input  logic       wb_we_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (use_i) begin
            if (mem_we_i && (mem_rd_i == src_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_we_i && (wb_rd_i == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: shadows EX/MEM/WB write metadata, drives forward selects,
// and stalls decode for one cycle when it consumes a load that is still in EX.
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              reset,
    ex_hazard_ctrl_if.slave  bus
);

    ex_stage_t        ex_q;
    ex_stage_t        ex_d;
    wr_stage_t        mem_q;
    wr_stage_t        wb_q;
    logic [CNT_W-1:0] stallCnt_q;
    logic [CNT_W-1:0] stallCnt_d;
    logic             haz;
    logic             stallInt;
    logic             bubbleInt;
    logic             unusedMemRead;

    assign haz = ex_q.mem_read & ex_q.reg_write &
                 ((bus.id_use_rs1 & (bus.id_rs1 == ex_q.rd)) |
                  (bus.id_use_rs2 & (bus.id_rs2 == ex_q.rd)) |
                  (bus.id_use_rd  & (bus.id_rd  == ex_q.rd)));

    // A taken branch kills the decode instruction, so there is nothing left to stall for
    assign stallInt  = haz & ~bus.flush;
    assign bubbleInt = haz | bus.flush;

    always_comb begin
        ex_d = '{rs1:       bus.id_rs1,
                 rs2:       bus.id_rs2,
                 rd:        bus.id_rd,
                 use_rs1:   bus.id_use_rs1,
                 use_rs2:   bus.id_use_rs2,
                 use_rd:    bus.id_use_rd,
                 reg_write: bus.id_reg_write,
                 mem_read:  bus.id_mem_read};
        if (bubbleInt) begin
            ex_d = '0;
        end
        stallCnt_d = stallCnt_q;
        if (stallInt && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            stallCnt_q <= '0;
        end else if (!bus.hold) begin
            ex_q       <= ex_d;
            mem_q      <= '{rd: ex_q.rd, reg_write: ex_q.reg_write, mem_read: ex_q.mem_read};
            wb_q       <= mem_q;
            stallCnt_q <= stallCnt_d;
        end
    end

    fwd_match u_fwd1 (
        .use_i    (ex_q.use_rs1),
        .src_i    (ex_q.rs1),
        .mem_rd_i (mem_q.rd),
        .mem_we_i (mem_q.reg_write),
        .wb_rd_i  (wb_q.rd),
        .wb_we_i  (wb_q.reg_write),
        .sel_o    (bus.muxFwd1select)
    );

    fwd_match u_fwd2 (
        .use_i    (ex_q.use_rs2),
        .src_i    (ex_q.rs2),
        .mem_rd_i (mem_q.rd),
        .mem_we_i (mem_q.reg_write),
        .wb_rd_i  (wb_q.rd),
        .wb_we_i  (wb_q.reg_write),
        .sel_o    (bus.muxFwd2select)
    );

    // Store data only has a WB bypass; a MEM-stage producer is covered by the register arg path
    assign bus.muxFwd3select = (ex_q.use_rd && wb_q.reg_write && (wb_q.rd == ex_q.rd))
                               ? FWD3_WB : FWD3_REG;

    assign bus.stall       = stallInt;
    assign bus.bubble      = bubbleInt;
    assign bus.stall_count = stallCnt_q;

    // Load flags are shadowed in MEM/WB for completeness but nothing downstream consumes them yet
    assign unusedMemRead = mem_q.mem_read ^ wb_q.mem_read;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed pipeline scenarios plus randomized
// traffic compared against an in-flight instruction list model.
module tb_ex_hazard_ctrl;
    import ex_ctrl_pkg::*;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    ex_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    ex_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction as seen by the model; index 0 = EX, 1 = MEM, 2 = WB
    typedef struct packed {
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic       u1;
        logic       u2;
        logic       ud;
        logic       we;
        logic       ld;
    } instr_t;

    instr_t pipe [3];
    int     modelCnt;

    function automatic instr_t decodeNow();
        instr_t i;
        i = '{rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd, u1: bus.id_use_rs1,
              u2: bus.id_use_rs2, ud: bus.id_use_rd, we: bus.id_reg_write, ld: bus.id_mem_read};
        return i;
    endfunction

    function automatic bit consumes(instr_t i, logic [2:0] r);
        return (i.u1 && i.rs1 == r) || (i.u2 && i.rs2 == r) || (i.ud && i.rd == r);
    endfunction

    function automatic bit modelHaz();
        return pipe[0].ld && pipe[0].we && consumes(decodeNow(), pipe[0].rd);
    endfunction

    // Newest in-flight producer of src wins; stage 1 is the ALU result, stage 2 is the load/WB data
    function automatic logic [1:0] modelFwd(logic u, logic [2:0] src);
        if (!u) return 2'b10;
        for (int s = 1; s <= 2; s++) begin
            if (pipe[s].we && pipe[s].rd == src) return (s == 1) ? 2'b00 : 2'b01;
        end
        return 2'b10;
    endfunction

    function automatic logic modelFwd3();
        return (pipe[0].ud && pipe[2].we && pipe[2].rd == pipe[0].rd) ? 1'b0 : 1'b1;
    endfunction

    task automatic setId(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] rd,
                         input logic u1, input logic u2, input logic ud,
                         input logic we, input logic ld);
        bus.id_rs1       = r1;
        bus.id_rs2       = r2;
        bus.id_rd        = rd;
        bus.id_use_rs1   = u1;
        bus.id_use_rs2   = u2;
        bus.id_use_rd    = ud;
        bus.id_reg_write = we;
        bus.id_mem_read  = ld;
    endtask

    task automatic setNop();
        setId(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Clock one edge and advance the model with the inputs that were present at that edge
    task automatic tick();
        bit haz;
        instr_t d;
        haz = modelHaz();
        d   = decodeNow();
        @(posedge clk);
        if (!reset) begin
            for (int s = 0; s < 3; s++) pipe[s] = '0;
            modelCnt = 0;
        end else if (!bus.hold) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (haz || bus.flush) ? instr_t'(0) : d;
            if (haz && !bus.flush && modelCnt < CNT_MAX) modelCnt++;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        reset     = 1'b0;
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        setNop();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) begin
            setId(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            bus.flush = 1'($urandom);
            bus.hold  = 1'($urandom);
            tick();
        end
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.muxFwd1select !== 2'b10) begin errors++; $display("[TB] FAIL rst_sel1: got %b want 10", bus.muxFwd1select); end
        checks++; if (bus.muxFwd2select !== 2'b10) begin errors++; $display("[TB] FAIL rst_sel2: got %b want 10", bus.muxFwd2select); end
        checks++; if (bus.muxFwd3select !== 1'b1) begin errors++; $display("[TB] FAIL rst_sel3: got %b want 1", bus.muxFwd3select); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b want 0", bus.stall); end
        checks++; if (bus.bubble !== 1'b0) begin errors++; $display("[TB] FAIL rst_bubble: got %b want 0", bus.bubble); end
        checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d want 0", bus.stall_count); end
        // Reset during a held load-use stall must clear the load out of EX
        reset    = 1'b1;
        bus.hold = 1'b0;
        setId(3'd1, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        setId(3'd5, 3'd5, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre: got %b want 1", bus.stall); end
        reset    = 1'b0;
        bus.hold = 1'b1;
        tick();
        reset    = 1'b1;
        bus.hold = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stall: got %b want 0", bus.stall); end
        checks++; if (bus.bubble !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_bubble: got %b want 0", bus.bubble); end
    endtask

    task automatic test_ex_forward();
        doReset();
        setId(3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        setId(3'd3, 3'd1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL exfwd_nostall: got %b want 0", bus.stall); end
        tick();
        setNop();
        #1;
        checks++; if (bus.muxFwd1select !== 2'b00) begin errors++; $display("[TB] FAIL exfwd_sel1: got %b want 00", bus.muxFwd1select); end
        checks++; if (bus.muxFwd2select !== 2'b10) begin errors++; $display("[TB] FAIL exfwd_sel2: got %b want 10", bus.muxFwd2select); end
    endtask

    task automatic test_double_write();
        for (int withNop = 0; withNop < 2; withNop++) begin
            doReset();
            setId(3'd1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            setId(3'd4, 3'd4, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            if (withNop == 1) begin
                setNop();
                tick();
            end
            setId(3'd2, 3'd3, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            setNop();
            #1;
            checks++;
            if (bus.muxFwd1select !== ((withNop == 1) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("[TB] FAIL dbl_sel1[nop=%0d]: got %b want %b", withNop, bus.muxFwd1select,
                         (withNop == 1) ? 2'b01 : 2'b00);
            end
            checks++; if (bus.muxFwd2select !== 2'b10) begin errors++; $display("[TB] FAIL dbl_sel2[nop=%0d]: got %b want 10", withNop, bus.muxFwd2select); end
        end
    endtask

    task automatic test_load_use();
        doReset();
        setId(3'd1, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        setId(3'd5, 3'd5, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall1: got %b want 1", bus.stall); end
        checks++; if (bus.bubble !== 1'b1) begin errors++; $display("[TB] FAIL lu_bubble1: got %b want 1", bus.bubble); end
        tick();
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall2: got %b want 0", bus.stall); end
        checks++; if (bus.bubble !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble2: got %b want 0", bus.bubble); end
        tick();
        setNop();
        #1;
        checks++; if (bus.muxFwd1select !== 2'b01) begin errors++; $display("[TB] FAIL lu_sel1: got %b want 01", bus.muxFwd1select); end
        checks++; if (bus.muxFwd2select !== 2'b01) begin errors++; $display("[TB] FAIL lu_sel2: got %b want 01", bus.muxFwd2select); end
        checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("[TB] FAIL lu_count: got %0d want 1", bus.stall_count); end
    endtask

    task automatic test_flush_hazard();
        doReset();
        setId(3'd1, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        setId(3'd5, 3'd5, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL fl_stall: got %b want 0", bus.stall); end
        checks++; if (bus.bubble !== 1'b1) begin errors++; $display("[TB] FAIL fl_bubble: got %b want 1", bus.bubble); end
        tick();
        bus.flush = 1'b0;
        setNop();
        #1;
        checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("[TB] FAIL fl_count: got %0d want 0", bus.stall_count); end
        checks++; if (bus.muxFwd1select !== 2'b10) begin errors++; $display("[TB] FAIL fl_exnop: got %b want 10", bus.muxFwd1select); end
    endtask

    task automatic test_hold();
        doReset();
        setId(3'd1, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        setId(3'd5, 3'd5, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_stall[%0d]: got %b want 1", c, bus.stall); end
            checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("[TB] FAIL hold_count[%0d]: got %0d want 0", c, bus.stall_count); end
            tick();
        end
        bus.hold = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_release: got %b want 1", bus.stall); end
        tick();
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL hold_done: got %b want 0", bus.stall); end
        checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("[TB] FAIL hold_count_after: got %0d want 1", bus.stall_count); end
        tick();
        setNop();
        #1;
        checks++; if (bus.muxFwd1select !== 2'b01) begin errors++; $display("[TB] FAIL hold_sel1: got %b want 01", bus.muxFwd1select); end
        checks++; if (bus.muxFwd2select !== 2'b01) begin errors++; $display("[TB] FAIL hold_sel2: got %b want 01", bus.muxFwd2select); end
    endtask

    task automatic test_saturate();
        int want;
        doReset();
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            setId(3'd1, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            tick();
            setId(3'd5, 3'd2, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            tick();
            want = (i + 1 > CNT_MAX) ? CNT_MAX : i + 1;
            checks++;
            if (bus.stall_count !== CW'(want)) begin
                errors++;
                $display("[TB] FAIL sat_count[%0d]: got %0d want %0d", i, bus.stall_count, want);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = (n == 0 || $urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            setId(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 99) < 40));
            bus.flush = ($urandom_range(0, 99) < 10);
            bus.hold  = ($urandom_range(0, 99) < 15);
            #1;
            checks++; if (bus.muxFwd1select !== modelFwd(pipe[0].u1, pipe[0].rs1)) begin errors++; $display("[TB] FAIL rnd_sel1[%0d]: got %b want %b", n, bus.muxFwd1select, modelFwd(pipe[0].u1, pipe[0].rs1)); end
            checks++; if (bus.muxFwd2select !== modelFwd(pipe[0].u2, pipe[0].rs2)) begin errors++; $display("[TB] FAIL rnd_sel2[%0d]: got %b want %b", n, bus.muxFwd2select, modelFwd(pipe[0].u2, pipe[0].rs2)); end
            checks++; if (bus.muxFwd3select !== modelFwd3()) begin errors++; $display("[TB] FAIL rnd_sel3[%0d]: got %b want %b", n, bus.muxFwd3select, modelFwd3()); end
            checks++; if (bus.stall !== (modelHaz() && !bus.flush)) begin errors++; $display("[TB] FAIL rnd_stall[%0d]: got %b want %b", n, bus.stall, modelHaz() && !bus.flush); end
            checks++; if (bus.bubble !== (modelHaz() || bus.flush)) begin errors++; $display("[TB] FAIL rnd_bubble[%0d]: got %b want %b", n, bus.bubble, modelHaz() || bus.flush); end
            checks++; if (bus.stall_count !== CW'(modelCnt)) begin errors++; $display("[TB] FAIL rnd_count[%0d]: got %0d want %0d", n, bus.stall_count, modelCnt); end
            tick();
        end
        reset     = 1'b1;
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        setNop();
        for (int s = 0; s < 3; s++) pipe[s] = '0;
        modelCnt = 0;
        @(negedge clk);
        test_reset();
        test_ex_forward();
        test_double_write();
        test_load_use();
        test_flush_hazard();
        test_hold();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
